// File: rtl/frame_store_writer.sv
// frame_store_writer: packs the macroblock-ordered 4:2:0 byte stream into
// 32-bit words and writes them to the planar ZBT frame buffer (late write).
module frame_store_writer #(
    parameter int DATA_DELAY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pic_start,
    input  logic [11:0] pic_width,
    input  logic [11:0] pic_height,
    input  logic [18:0] Y_start,
    input  logic [18:0] CB_start,
    input  logic [18:0] CR_start,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        ZBT_busy,
    output logic [18:0] ZBT_addr,
    output logic        ZBT_we_n,
    output logic [31:0] ZBT_dataout,
    output logic        ZBT_data_oe,
    output logic        pic_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t r_state, w_next;

    logic [7:0]  r_mbw, r_mbh;
    logic [9:0]  r_lw4;
    logic [18:0] r_y, r_cb, r_cr;
    logic [5:0]  r_pos;
    logic [2:0]  r_blk;
    logic [7:0]  r_mbx, r_mby;
    logic [23:0] r_pack;
    logic        r_pend, r_plast, r_lastdone, r_olast;
    logic [31:0] r_pword;
    logic [18:0] r_paddr;

    logic [DATA_DELAY-1:0] r_dv, r_dl;
    logic [31:0]           r_dd [DATA_DELAY];

    logic        w_accept, w_issue, w_final, w_last_oe, w_done;
    logic [11:0] w_line;
    logic [9:0]  w_col, w_stride;
    logic [18:0] w_base, w_addr;
    logic [21:0] w_prod;
    logic        w_unused;

    assign w_unused  = ^{pic_width[1:0], pic_height[3:0], w_prod[21:19]};
    assign pix_ready = (r_state == S_RUN) && !(r_pend && ZBT_busy) && !r_lastdone;
    assign w_accept  = pix_valid && pix_ready && !pic_start;
    assign w_issue   = r_pend && !ZBT_busy && !pic_start;
    assign w_final   = (r_pos == 6'd63) && (r_blk == 3'd5)
                    && (r_mbx == r_mbw - 8'd1) && (r_mby == r_mbh - 8'd1);
    assign w_last_oe = ZBT_data_oe && r_olast;
    assign w_prod    = {10'd0, w_line} * {12'd0, w_stride};
    assign w_addr    = w_base + w_prod[18:0] + {9'd0, w_col};

    // Frame-buffer word address of the word currently being assembled
    always_comb begin
        w_line   = '0;
        w_col    = '0;
        w_stride = r_lw4;
        w_base   = r_y;
        if (r_blk[2]) begin
            w_line   = {1'b0, r_mby, 3'b000} + {9'd0, r_pos[5:3]};
            w_col    = {1'b0, r_mbx, 1'b0} + {9'd0, r_pos[2]};
            w_stride = {1'b0, r_lw4[9:1]};
            w_base   = r_blk[0] ? r_cr : r_cb;
        end else begin
            w_line = {r_mby, 4'b0000} + {8'd0, r_blk[1], 3'b000}
                   + {9'd0, r_pos[5:3]};
            w_col  = {r_mbx, 2'b00} + {8'd0, r_blk[0], 1'b0}
                   + {9'd0, r_pos[2]};
        end
    end

    // Picture sequencing: run until the last word issues, drain its data phase
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE:  if (pic_start) w_next = S_RUN;
            S_RUN: begin
                if (pic_start) w_next = S_RUN;
                else if (w_issue && r_plast) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (pic_start) begin
                    w_next = S_RUN;
                end else if (w_last_oe) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Packing, stream counters, write issue and late-write data pipeline
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mbw       <= '0;
            r_mbh       <= '0;
            r_lw4       <= '0;
            r_y         <= '0;
            r_cb        <= '0;
            r_cr        <= '0;
            r_pos       <= '0;
            r_blk       <= '0;
            r_mbx       <= '0;
            r_mby       <= '0;
            r_pack      <= '0;
            r_pend      <= 1'b0;
            r_plast     <= 1'b0;
            r_lastdone  <= 1'b0;
            r_pword     <= '0;
            r_paddr     <= '0;
            r_dv        <= '0;
            r_dl        <= '0;
            for (int i = 0; i < DATA_DELAY; i++) r_dd[i] <= '0;
            r_olast     <= 1'b0;
            ZBT_addr    <= '0;
            ZBT_we_n    <= 1'b1;
            ZBT_dataout <= '0;
            ZBT_data_oe <= 1'b0;
            pic_done    <= 1'b0;
        end else begin
            ZBT_we_n <= 1'b1;
            if (w_issue) begin
                ZBT_addr <= r_paddr;
                ZBT_we_n <= 1'b0;
            end
            r_dv[0] <= w_issue;
            r_dd[0] <= r_pword;
            r_dl[0] <= w_issue && r_plast;
            for (int i = 1; i < DATA_DELAY; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_dd[i] <= r_dd[i-1];
                r_dl[i] <= r_dl[i-1] && !pic_start;
            end
            ZBT_data_oe <= r_dv[DATA_DELAY-1];
            ZBT_dataout <= r_dv[DATA_DELAY-1] ? r_dd[DATA_DELAY-1] : 32'd0;
            r_olast     <= r_dl[DATA_DELAY-1] && !pic_start;
            pic_done    <= w_done;

            if (pic_start) begin
                r_mbw      <= pic_width[11:4];
                r_mbh      <= pic_height[11:4];
                r_lw4      <= pic_width[11:2];
                r_y        <= Y_start;
                r_cb       <= CB_start;
                r_cr       <= CR_start;
                r_pos      <= '0;
                r_blk      <= '0;
                r_mbx      <= '0;
                r_mby      <= '0;
                r_pend     <= 1'b0;
                r_plast    <= 1'b0;
                r_lastdone <= 1'b0;
            end else begin
                if (w_issue) r_pend <= 1'b0;
                if (w_accept) begin
                    r_pack <= {r_pack[15:0], pix_data};
                    r_pos  <= r_pos + 6'd1;
                    if (r_pos == 6'd63) begin
                        if (r_blk == 3'd5) begin
                            r_blk <= '0;
                            if (r_mbx == r_mbw - 8'd1) begin
                                r_mbx <= '0;
                                r_mby <= r_mby + 8'd1;
                            end else begin
                                r_mbx <= r_mbx + 8'd1;
                            end
                        end else begin
                            r_blk <= r_blk + 3'd1;
                        end
                    end
                    if (r_pos[1:0] == 2'd3) begin
                        r_pend  <= 1'b1;
                        r_pword <= {r_pack, pix_data};
                        r_paddr <= w_addr;
                        r_plast <= w_final;
                        if (w_final) r_lastdone <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_store_writer.sv
// tb_frame_store_writer: directed checks of packing, addressing, ZBT timing,
// busy stalls, restart, async reset and idle behaviour.
module tb_frame_store_writer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pic_start;
    logic [11:0] pic_width, pic_height;
    logic [18:0] Y_start, CB_start, CR_start;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        ZBT_busy;
    logic [18:0] ZBT_addr;
    logic        ZBT_we_n;
    logic [31:0] ZBT_dataout;
    logic        ZBT_data_oe;
    logic        pic_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first4;
    int busy_fall;
    int busy_bad;

    int          waddr[$];
    int          wcyc[$];
    int          dcyc[$];
    int          done_cyc[$];
    logic [31:0] ddata[$];

    frame_store_writer #(.DATA_DELAY(2)) dut (
        .clk(clk), .resetn(resetn), .pic_start(pic_start),
        .pic_width(pic_width), .pic_height(pic_height),
        .Y_start(Y_start), .CB_start(CB_start), .CR_start(CR_start),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .ZBT_busy(ZBT_busy), .ZBT_addr(ZBT_addr), .ZBT_we_n(ZBT_we_n),
        .ZBT_dataout(ZBT_dataout), .ZBT_data_oe(ZBT_data_oe),
        .pic_done(pic_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!ZBT_we_n) begin
            waddr.push_back(int'(ZBT_addr));
            wcyc.push_back(cyc);
        end
        if (ZBT_data_oe) begin
            ddata.push_back(ZBT_dataout);
            dcyc.push_back(cyc);
        end
        if (pic_done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ew(input int k, input int off);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*k + off + 1);
        b1 = 8'(4*k + off + 2);
        b2 = 8'(4*k + off + 3);
        b3 = 8'(4*k + off + 4);
        return {b0, b1, b2, b3};
    endfunction

    function automatic int data_bad(input int first, input int n,
                                    input int off);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (first + k >= ddata.size()) bad++;
            else if (ddata[first+k] !== ew(k, off)) bad++;
        end
        return bad;
    endfunction

    task automatic chk_perm(input string tag, input int n);
        int hits[];
        int bad = 0;
        hits = new[n];
        foreach (waddr[i]) begin
            if (waddr[i] >= 0 && waddr[i] < n) hits[waddr[i]]++;
            else bad++;
        end
        for (int a = 0; a < n; a++) if (hits[a] != 1) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic clear_log();
        waddr.delete();
        wcyc.delete();
        dcyc.delete();
        ddata.delete();
        done_cyc.delete();
    endtask

    task automatic setup(input int w, input int h, input int y,
                         input int cb, input int cr);
        pic_width  = 12'(w);
        pic_height = 12'(h);
        Y_start    = 19'(y);
        CB_start   = 19'(cb);
        CR_start   = 19'(cr);
        clear_log();
        first4 = -1;
        @(negedge clk);
        pic_start = 1'b1;
    endtask

    // ev_kind: 1 = busy for 5 cycles, 2 = restart, 3 = async reset
    task automatic drive(input int n, input int off_in, input int ev_at,
                         input int ev_kind);
        int idx = 0;
        int off = off_in;
        int busy_left = 0;
        bit acc = 0;
        bit fired = 0;
        for (int cy = 0; cy < 6000; cy++) begin
            @(negedge clk);
            pic_start = 1'b0;
            if (acc) idx++;
            acc = 0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    ZBT_busy  = 1'b0;
                    busy_fall = cyc;
                end
            end
            if (!fired && ev_kind != 0 && idx == ev_at) begin
                fired = 1;
                if (ev_kind == 1) begin
                    ZBT_busy  = 1'b1;
                    busy_left = 5;
                end else if (ev_kind == 2) begin
                    pic_start = 1'b1;
                    Y_start   = 19'h100;
                    CB_start  = 19'h140;
                    CR_start  = 19'h150;
                    idx       = 0;
                    off       = off + 64;
                    pix_valid = 1'b0;
                end else begin
                    #2 resetn = 1'b0;
                    #1;
                    chk("async_rst",
                        {ZBT_addr, ZBT_we_n, ZBT_dataout, ZBT_data_oe,
                         pix_ready, pic_done},
                        {19'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
                    return;
                end
            end
            if (!pic_start) begin
                pix_valid = (idx < n);
                pix_data  = 8'(idx + off + 1);
            end
            #1;
            acc = pix_valid && pix_ready;
            if (acc && idx == 3 && first4 < 0) first4 = cyc;
            if (ZBT_busy && (pix_ready || !ZBT_we_n)) busy_bad++;
            if (idx == n) return;
        end
        chk("drive_timeout", 64'(idx), 64'(n));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_cyc.size() > 0) break;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int bad;
        resetn     = 1'b0;
        pic_start  = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        ZBT_busy   = 1'b0;
        pic_width  = '0;
        pic_height = '0;
        Y_start    = '0;
        CB_start   = '0;
        CR_start   = '0;
        busy_fall  = 0;
        busy_bad   = 0;
        first4     = -1;
        repeat (3) @(negedge clk);
        chk("reset_vals",
            {ZBT_addr, ZBT_we_n, ZBT_dataout, ZBT_data_oe, pix_ready, pic_done},
            {19'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 16x16 basic picture
        setup(16, 16, 0, 64, 80);
        drive(384, 0, 0, 0);
        wait_done();
        chk("A_nwr", 64'(waddr.size()), 64'd96);
        chk("A_ndata", 64'(ddata.size()), 64'd96);
        if (waddr.size() == 96 && ddata.size() == 96) begin
            chk("A_addr0", 64'(waddr[0]), 64'd0);
            chk("A_we_lat", 64'(wcyc[0]), 64'(first4 + 2));
            chk("A_data0", 64'(ddata[0]), 64'h01020304);
            chk("A_d_lat", 64'(dcyc[0]), 64'(wcyc[0] + 2));
            chk("A_y0w1", 64'(waddr[1]), 64'd1);
            chk("A_y0r1", 64'(waddr[2]), 64'd4);
            chk("A_y1", 64'(waddr[16]), 64'd2);
            chk("A_y2", 64'(waddr[32]), 64'd32);
            chk("A_y3", 64'(waddr[48]), 64'd34);
            chk("A_cb", 64'(waddr[64]), 64'd64);
            chk("A_cr", 64'(waddr[80]), 64'd80);
            chk("A_last", 64'(waddr[95]), 64'd95);
            for (int k = 0; k < 96; k++) chk("A_word", 64'(ddata[k]), 64'(ew(k, 0)));
            chk_perm("A_perm", 96);
            if (done_cyc.size() > 0)
                chk("A_done_cyc", 64'(done_cyc[0]), 64'(dcyc[95] + 1));
        end
        chk("A_ndone", 64'(done_cyc.size()), 64'd1);

        // busy held 5 cycles while word 9 is pending
        setup(16, 16, 0, 64, 80);
        busy_bad = 0;
        drive(384, 0, 40, 1);
        wait_done();
        chk("B_busy_hold", 64'(busy_bad), 64'd0);
        chk("B_nwr", 64'(waddr.size()), 64'd96);
        if (waddr.size() == 96 && ddata.size() == 96) begin
            chk("B_issue", 64'(wcyc[9]), 64'(busy_fall + 1));
            chk("B_data_lat", 64'(dcyc[9]), 64'(wcyc[9] + 2));
            chk("B_words", 64'(data_bad(0, 96, 0)), 64'd0);
            chk_perm("B_perm", 96);
        end
        chk("B_ndone", 64'(done_cyc.size()), 64'd1);

        // restart after 200 bytes with new bases
        setup(16, 16, 0, 64, 80);
        drive(384, 0, 200, 2);
        wait_done();
        chk("C_nwr", 64'(waddr.size()), 64'd145);
        chk("C_ndata", 64'(ddata.size()), 64'd145);
        if (waddr.size() == 145 && ddata.size() == 145) begin
            chk("C_new_addr", 64'(waddr[49]), 64'h100);
            chk("C_new_data", 64'(ddata[49]), 64'h41424344);
            chk("C_old_words", 64'(data_bad(0, 49, 0)), 64'd0);
            chk("C_new_words", 64'(data_bad(49, 96, 64)), 64'd0);
            chk("C_last", 64'(waddr[144]), 64'h15F);
        end
        chk("C_ndone", 64'(done_cyc.size()), 64'd1);

        // 32x32 picture, 2x2 macroblocks
        setup(32, 32, 0, 256, 320);
        drive(1536, 0, 0, 0);
        wait_done();
        chk("D_nwr", 64'(waddr.size()), 64'd384);
        if (waddr.size() == 384) begin
            chk_perm("D_perm", 384);
            chk("D_mb1_y0", 64'(waddr[96]), 64'd4);
            chk("D_mb2_y0", 64'(waddr[192]), 64'd128);
            chk("D_cr0", 64'(waddr[80]), 64'd320);
            chk("D_last", 64'(waddr[383]), 64'd383);
            chk("D_words", 64'(data_bad(0, 384, 0)), 64'd0);
        end
        chk("D_ndone", 64'(done_cyc.size()), 64'd1);

        // async reset mid-stream, then pix_valid held in IDLE
        setup(16, 16, 0, 64, 80);
        drive(384, 0, 100, 3);
        pix_valid = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clear_log();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (pix_ready || !ZBT_we_n) bad++;
        end
        pix_valid = 1'b0;
        chk("E_idle_ready", 64'(bad), 64'd0);
        chk("E_idle_nwr", 64'(waddr.size()), 64'd0);
        chk("E_idle_done", 64'(done_cyc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
